// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: frame layout,
// status-byte fields, FSM encoding and delta saturation helper.
package mouse_pkg;

  localparam int FRM_START    = 10;
  localparam int FRM_DATA_MSB = 9;
  localparam int FRM_DATA_LSB = 2;
  localparam int FRM_PARITY   = 1;
  localparam int FRM_STOP     = 0;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  localparam int DELTA_MAX = 255;
  localparam int DELTA_MIN = -256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    APPLY  = 3'd2,
    REJECT = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // An overflowed axis reports its extreme value in the direction of its sign.
  function automatic logic signed [8:0] decodeDelta(input logic sign, input logic ovf,
                                                    input logic [7:0] mag);
    if (ovf) begin
      return sign ? 9'(DELTA_MIN) : 9'(DELTA_MAX);
    end
    return {sign, mag};
  endfunction

endpackage

// File: rtl/ps2_frame_check.sv
// Combinational check of one 11-bit PS/2 frame: start, stop and odd parity,
// plus extraction of the data byte (first-arriving bit is the LSB).
module ps2_frame_check
  import mouse_pkg::*;
(
  input  logic [10:0] i_frame,
  output logic [7:0]  o_data,
  output logic        o_ok
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i <= FRM_DATA_MSB - FRM_DATA_LSB; i++) begin
      o_data[i] = i_frame[FRM_DATA_MSB - i];
    end
  end

  assign o_ok = ~i_frame[FRM_START] & i_frame[FRM_STOP] &
                (^i_frame[FRM_DATA_MSB:FRM_PARITY]);

endmodule

// File: rtl/mouse_packet_decoder.sv
// Decodes a latched three-frame PS/2 mouse packet into buttons, deltas and a
// screen-clamped cursor position; rejected packets are counted.
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          valid,
  input  logic [32:0]   mouseData,
  output logic [2:0]    buttons,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [8:0]    dx,
  output logic [8:0]    dy,
  output logic          update,
  output logic          frame_err,
  output logic [7:0]    err_count
);

  localparam logic signed [XW+1:0] X_LIMIT = (XW+2)'(SCREEN_W - 1);
  localparam logic signed [YW+1:0] Y_LIMIT = (YW+2)'(SCREEN_H - 1);

  state_t      r_state;
  logic [32:0] r_packet;

  logic [7:0] w_status;
  logic [7:0] w_xByte;
  logic [7:0] w_yByte;
  logic       w_ok0;
  logic       w_ok1;
  logic       w_ok2;
  logic       w_packetOk;

  logic signed [8:0]    w_dx;
  logic signed [8:0]    w_dy;
  logic signed [XW+1:0] w_sumX;
  logic signed [YW+1:0] w_sumY;
  logic [XW-1:0]        w_nextX;
  logic [YW-1:0]        w_nextY;

  ps2_frame_check u_frame0 (.i_frame(r_packet[32:22]), .o_data(w_status), .o_ok(w_ok0));
  ps2_frame_check u_frame1 (.i_frame(r_packet[21:11]), .o_data(w_xByte),  .o_ok(w_ok1));
  ps2_frame_check u_frame2 (.i_frame(r_packet[10:0]),  .o_data(w_yByte),  .o_ok(w_ok2));

  assign w_packetOk = w_ok0 & w_ok1 & w_ok2 & w_status[SYNC];

  assign w_dx = decodeDelta(w_status[XSIGN], w_status[XOVF], w_xByte);
  assign w_dy = decodeDelta(w_status[YSIGN], w_status[YOVF], w_yByte);

  // Screen Y grows downward while the mouse reports up as positive.
  assign w_sumX = $signed({2'b00, pos_x}) + $signed({{(XW-7){w_dx[8]}}, w_dx});
  assign w_sumY = $signed({2'b00, pos_y}) - $signed({{(YW-7){w_dy[8]}}, w_dy});

  always_comb begin
    w_nextX = w_sumX[XW-1:0];
    if (w_sumX[XW+1]) begin
      w_nextX = '0;
    end else if (w_sumX > X_LIMIT) begin
      w_nextX = X_LIMIT[XW-1:0];
    end
  end

  always_comb begin
    w_nextY = w_sumY[YW-1:0];
    if (w_sumY[YW+1]) begin
      w_nextY = '0;
    end else if (w_sumY > Y_LIMIT) begin
      w_nextY = Y_LIMIT[YW-1:0];
    end
  end

  // HOLD waits for valid to fall so each valid assertion decodes exactly once.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_packet  <= '0;
      buttons   <= '0;
      pos_x     <= XW'(X_INIT);
      pos_y     <= YW'(Y_INIT);
      dx        <= '0;
      dy        <= '0;
      update    <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      update    <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_packet <= mouseData;
            r_state  <= CHECK;
          end
        end
        CHECK: begin
          r_state <= w_packetOk ? APPLY : REJECT;
        end
        APPLY: begin
          buttons <= {w_status[BTN_M], w_status[BTN_R], w_status[BTN_L]};
          dx      <= w_dx;
          dy      <= w_dy;
          pos_x   <= w_nextX;
          pos_y   <= w_nextY;
          update  <= 1'b1;
          r_state <= HOLD;
        end
        REJECT: begin
          frame_err <= 1'b1;
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
          r_state <= HOLD;
        end
        HOLD: begin
          if (!valid) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Self-checking bench for mouse_packet_decoder: directed scenarios plus a
// randomized run, all compared against a behavioural mouse-state model.
module tb_mouse_packet_decoder;

  localparam int XW = 10;
  localparam int YW = 9;

  logic          ck = 1'b0;
  logic          reset;
  logic          valid;
  logic [32:0]   mouseData;
  logic [2:0]    buttons;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [8:0]    dx;
  logic [8:0]    dy;
  logic          update;
  logic          frame_err;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  int       mPosX;
  int       mPosY;
  int       mDx;
  int       mDy;
  int       mErr;
  logic [2:0] mBtn;

  mouse_packet_decoder dut (
    .ck(ck), .reset(reset), .valid(valid), .mouseData(mouseData),
    .buttons(buttons), .pos_x(pos_x), .pos_y(pos_y), .dx(dx), .dy(dy),
    .update(update), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 ck = ~ck;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Build a correctly framed 11-bit PS/2 frame from a data byte.
  function automatic logic [10:0] makeFrame(input logic [7:0] d);
    logic [10:0] f;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[9-i] = d[i];
    f[1] = ~^d;
    f[0] = 1'b1;
    return f;
  endfunction

  function automatic logic [7:0] frameData(input logic [10:0] f);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = f[9-i];
    return d;
  endfunction

  function automatic bit frameOk(input logic [10:0] f);
    logic [8:0] body;
    body = f[9:1];
    return (f[10] == 1'b0) && (f[0] == 1'b1) && (($countones(body) % 2) == 1);
  endfunction

  function automatic logic [32:0] makePacket(input logic [2:0] btn, input int ddx, input int ddy,
                                             input bit xo, input bit yo, input bit sync);
    logic [7:0]  st;
    logic [31:0] ux;
    logic [31:0] uy;
    ux = ddx;
    uy = ddy;
    st = {yo, xo, (ddy < 0), (ddx < 0), sync, btn};
    return {makeFrame(st), makeFrame(ux[7:0]), makeFrame(uy[7:0])};
  endfunction

  function automatic int clampI(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic modelReset();
    mPosX = 320; mPosY = 240; mDx = 0; mDy = 0; mErr = 0; mBtn = 3'b000;
  endtask

  task automatic modelApply(input logic [32:0] pkt, output bit ok);
    logic [7:0] st;
    logic [7:0] xb;
    logic [7:0] yb;
    int xv;
    int yv;
    st = frameData(pkt[32:22]);
    xb = frameData(pkt[21:11]);
    yb = frameData(pkt[10:0]);
    ok = frameOk(pkt[32:22]) && frameOk(pkt[21:11]) && frameOk(pkt[10:0]) && st[3];
    if (ok) begin
      if (st[6]) xv = st[4] ? -256 : 255;
      else       xv = st[4] ? int'(xb) - 256 : int'(xb);
      if (st[7]) yv = st[5] ? -256 : 255;
      else       yv = st[5] ? int'(yb) - 256 : int'(yb);
      mDx = xv;
      mDy = yv;
      mPosX = clampI(mPosX + xv, 0, 639);
      mPosY = clampI(mPosY - yv, 0, 479);
      mBtn = st[2:0];
    end else if (mErr < 255) begin
      mErr++;
    end
  endtask

  // Drives one valid assertion for hold cycles, scrambling mouseData after the latch edge.
  task automatic runPacket(input logic [32:0] pkt, input int hold, output int nUpd, output int nErr,
                           output int lat, output int nBoth, output bit expOk);
    logic [63:0] junk;
    modelApply(pkt, expOk);
    nUpd = 0; nErr = 0; nBoth = 0; lat = -1;
    @(negedge ck);
    mouseData = pkt;
    valid = 1'b1;
    for (int c = 1; c <= hold + 4; c++) begin
      @(negedge ck);
      if ((update || frame_err) && lat < 0) lat = c;
      if (update) nUpd++;
      if (frame_err) nErr++;
      if (update && frame_err) nBoth++;
      junk = {$urandom, $urandom};
      mouseData = junk[32:0];
      if (c == hold) valid = 1'b0;
    end
  endtask

  task automatic moveTo(input int tx, input int ty);
    int nU, nE, lat, nB;
    bit ok;
    for (int k = 0; k < 8 && (mPosX != tx || mPosY != ty); k++) begin
      runPacket(makePacket(3'b000, clampI(tx - mPosX, -256, 255), clampI(mPosY - ty, -256, 255),
                           1'b0, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
    end
  endtask

  task automatic test_basic();
    int nU, nE, lat, nB;
    bit ok;
    runPacket(makePacket(3'b001, 5, 3, 1'b0, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
    checks++; if (nU !== 1) begin errors++; $display("[TB] FAIL basic update_cycles: got %0d expected 1", nU); end
    checks++; if (nE !== 0) begin errors++; $display("[TB] FAIL basic frame_err_cycles: got %0d expected 0", nE); end
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL basic latency: got %0d expected 3", lat); end
    checks++; if (buttons !== 3'b001) begin errors++; $display("[TB] FAIL basic buttons: got %b expected 001", buttons); end
    checks++; if (dx !== 9'd5) begin errors++; $display("[TB] FAIL basic dx: got %0d expected 5", dx); end
    checks++; if (dy !== 9'd3) begin errors++; $display("[TB] FAIL basic dy: got %0d expected 3", dy); end
    checks++; if (pos_x !== 10'd325) begin errors++; $display("[TB] FAIL basic pos_x: got %0d expected 325", pos_x); end
    checks++; if (pos_y !== 9'd237) begin errors++; $display("[TB] FAIL basic pos_y: got %0d expected 237", pos_y); end
  endtask

  task automatic test_reset();
    int nU, nE, lat, nB;
    bit ok;
    runPacket(makePacket(3'b110, 9, -9, 1'b0, 1'b0, 1'b0), 3, nU, nE, lat, nB, ok);
    @(negedge ck);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checks++; if (pos_x !== 10'd320) begin errors++; $display("[TB] FAIL reset pos_x: got %0d expected 320", pos_x); end
    checks++; if (pos_y !== 9'd240) begin errors++; $display("[TB] FAIL reset pos_y: got %0d expected 240", pos_y); end
    checks++; if (buttons !== 3'b000) begin errors++; $display("[TB] FAIL reset buttons: got %b expected 000", buttons); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset err_count: got %0d expected 0", err_count); end
    checks++; if (dx !== 9'd0 || dy !== 9'd0) begin errors++; $display("[TB] FAIL reset deltas: got %0d/%0d expected 0/0", dx, dy); end
    checks++; if (update !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset pulses: got %b%b expected 00", update, frame_err); end
    @(negedge ck);
    reset = 1'b1;
  endtask

  task automatic test_negative_clamp();
    int nU, nE, lat, nB;
    bit ok;
    moveTo(2, 478);
    checks++; if (pos_x !== 10'd2 || pos_y !== 9'd478) begin errors++; $display("[TB] FAIL clamp setup_pos: got (%0d,%0d) expected (2,478)", pos_x, pos_y); end
    runPacket(makePacket(3'b000, -10, -5, 1'b0, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
    checks++; if (dx !== 9'h1F6) begin errors++; $display("[TB] FAIL clamp neg_dx: got %h expected 1f6", dx); end
    checks++; if (pos_x !== 10'd0 || pos_y !== 9'd479) begin errors++; $display("[TB] FAIL clamp low_corner: got (%0d,%0d) expected (0,479)", pos_x, pos_y); end
    for (int k = 1; k <= 6; k++) begin
      runPacket(makePacket(3'b000, 127, 127, 1'b0, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
      checks++; if (nU !== 1) begin errors++; $display("[TB] FAIL clamp step%0d_update: got %0d expected 1", k, nU); end
      if (k == 5) begin
        checks++; if (pos_x !== 10'd635) begin errors++; $display("[TB] FAIL clamp x_after5: got %0d expected 635", pos_x); end
      end
    end
    checks++; if (pos_x !== 10'd639) begin errors++; $display("[TB] FAIL clamp x_after6: got %0d expected 639", pos_x); end
    checks++; if (pos_y !== 9'd0) begin errors++; $display("[TB] FAIL clamp y_top: got %0d expected 0", pos_y); end
  endtask

  task automatic test_overflow();
    int nU, nE, lat, nB;
    bit ok;
    runPacket(makePacket(3'b000, 8'h12, 0, 1'b1, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
    checks++; if (dx !== 9'h0FF) begin errors++; $display("[TB] FAIL ovf pos_x_sat: got %h expected 0ff", dx); end
    runPacket(makePacket(3'b000, -5, 0, 1'b1, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
    checks++; if (dx !== 9'h100) begin errors++; $display("[TB] FAIL ovf neg_x_sat: got %h expected 100", dx); end
    checks++; if (pos_x !== XW'(mPosX)) begin errors++; $display("[TB] FAIL ovf pos_x: got %0d expected %0d", pos_x, mPosX); end
    runPacket(makePacket(3'b000, 0, -3, 1'b0, 1'b1, 1'b1), 3, nU, nE, lat, nB, ok);
    checks++; if (dy !== 9'h100) begin errors++; $display("[TB] FAIL ovf neg_y_sat: got %h expected 100", dy); end
    checks++; if (pos_y !== YW'(mPosY)) begin errors++; $display("[TB] FAIL ovf pos_y: got %0d expected %0d", pos_y, mPosY); end
  endtask

  task automatic test_frame_errors();
    logic [32:0] good;
    logic [32:0] bad [4];
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [2:0]    b;
    int nU, nE, lat, nB;
    bit ok;
    good = makePacket(3'b101, 7, -4, 1'b0, 1'b0, 1'b1);
    bad[0] = good ^ (33'h1 << 12);
    bad[1] = good & ~33'h1;
    bad[2] = makePacket(3'b101, 7, -4, 1'b0, 1'b0, 1'b0);
    bad[3] = good ^ (33'h1 << 32);
    px = pos_x; py = pos_y; b = buttons;
    for (int k = 0; k < 4; k++) begin
      runPacket(bad[k], 3, nU, nE, lat, nB, ok);
      checks++; if (nE !== 1 || nU !== 0) begin errors++; $display("[TB] FAIL ferr%0d pulses: got err=%0d upd=%0d expected err=1 upd=0", k, nE, nU); end
      checks++; if (err_count !== 8'(k + 1)) begin errors++; $display("[TB] FAIL ferr%0d err_count: got %0d expected %0d", k, err_count, k + 1); end
      checks++; if (pos_x !== px || pos_y !== py || buttons !== b) begin errors++; $display("[TB] FAIL ferr%0d state_kept: got (%0d,%0d,%b) expected (%0d,%0d,%b)", k, pos_x, pos_y, buttons, px, py, b); end
    end
  endtask

  task automatic test_held_valid();
    int nU, nE, lat, nB;
    bit ok;
    runPacket(makePacket(3'b010, -20, 15, 1'b0, 1'b0, 1'b1), 50, nU, nE, lat, nB, ok);
    checks++; if (nU !== 1) begin errors++; $display("[TB] FAIL held single_update: got %0d expected 1", nU); end
    runPacket(makePacket(3'b100, 30, -1, 1'b0, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
    checks++; if (nU !== 1) begin errors++; $display("[TB] FAIL held second_decode: got %0d expected 1", nU); end
    checks++; if (buttons !== mBtn || pos_x !== XW'(mPosX) || pos_y !== YW'(mPosY)) begin errors++; $display("[TB] FAIL held second_state: got (%b,%0d,%0d) expected (%b,%0d,%0d)", buttons, pos_x, pos_y, mBtn, mPosX, mPosY); end
  endtask

  task automatic test_midop_reset();
    int nU, nE, lat, nB;
    int pulses;
    bit ok;
    @(negedge ck);
    mouseData = makePacket(3'b011, 50, 50, 1'b0, 1'b0, 1'b1);
    valid = 1'b1;
    @(negedge ck);
    reset = 1'b0;
    #1;
    modelReset();
    checks++; if (update !== 1'b0 || pos_x !== 10'd320 || pos_y !== 9'd240) begin errors++; $display("[TB] FAIL midreset state: got upd=%b pos=(%0d,%0d) expected 0 (320,240)", update, pos_x, pos_y); end
    @(negedge ck);
    reset = 1'b1;
    valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge ck);
      if (update || frame_err) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL midreset no_pulse: got %0d expected 0", pulses); end
    runPacket(makePacket(3'b001, 1, 1, 1'b0, 1'b0, 1'b1), 3, nU, nE, lat, nB, ok);
    checks++; if (nU !== 1 || lat !== 3) begin errors++; $display("[TB] FAIL midreset recover: got upd=%0d lat=%0d expected 1 3", nU, lat); end
  endtask

  task automatic test_random();
    logic [32:0] pkt;
    int nU, nE, lat, nB;
    bit ok;
    for (int k = 0; k < 60; k++) begin
      pkt = makePacket(3'($urandom_range(0, 7)), int'($urandom_range(0, 511)) - 256,
                       int'($urandom_range(0, 511)) - 256, ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) pkt = pkt ^ (33'h1 << $urandom_range(0, 32));
      runPacket(pkt, int'($urandom_range(3, 6)), nU, nE, lat, nB, ok);
      checks++; if (nU !== int'(ok) || nE !== int'(!ok) || nB !== 0 || lat !== 3) begin errors++; $display("[TB] FAIL rand%0d pulses: got upd=%0d err=%0d both=%0d lat=%0d expected upd=%0d err=%0d lat=3", k, nU, nE, nB, lat, ok, !ok); end
      checks++; if (buttons !== mBtn || dx !== 9'(mDx) || dy !== 9'(mDy)) begin errors++; $display("[TB] FAIL rand%0d decode: got (%b,%0d,%0d) expected (%b,%0d,%0d)", k, buttons, $signed(dx), $signed(dy), mBtn, mDx, mDy); end
      checks++; if (pos_x !== XW'(mPosX) || pos_y !== YW'(mPosY) || err_count !== 8'(mErr)) begin errors++; $display("[TB] FAIL rand%0d position: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", k, pos_x, pos_y, err_count, mPosX, mPosY, mErr); end
    end
  endtask

  task automatic test_err_saturation();
    logic [32:0] pkt;
    int nU, nE, lat, nB;
    bit ok;
    for (int k = 0; k < 260; k++) begin
      pkt = makePacket(3'($urandom_range(0, 7)), int'($urandom_range(0, 100)), 0, 1'b0, 1'b0, 1'b1);
      pkt = pkt ^ (33'h1 << $urandom_range(0, 32));
      runPacket(pkt, 3, nU, nE, lat, nB, ok);
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat err_count: got %0d expected 255", err_count); end
    checks++; if (nE !== 1) begin errors++; $display("[TB] FAIL sat pulse_at_max: got %0d expected 1", nE); end
    checks++; if (pos_x !== XW'(mPosX) || pos_y !== YW'(mPosY)) begin errors++; $display("[TB] FAIL sat pos_kept: got (%0d,%0d) expected (%0d,%0d)", pos_x, pos_y, mPosX, mPosY); end
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    mouseData = '0;
    modelReset();
    repeat (2) @(negedge ck);
    reset = 1'b1;
    test_basic();
    test_reset();
    test_negative_clamp();
    test_overflow();
    test_frame_errors();
    test_held_valid();
    test_midop_reset();
    test_random();
    test_err_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_packet_decoder.md
Name: mouse_packet_decoder

Overview:
Consumes the 33-bit three-frame packet from the packet register stage (valid + mouseData) and decodes it into PS/2 mouse state.
- Checks the framing of each 11-bit frame and the protocol sync bit.
- Extracts button states and 9-bit signed X/Y deltas.
- Keeps a cursor position clamped to the screen bounds.
- Feeds the display/cursor logic downstream.

Parameters:
SCREEN_W, 640, horizontal extent; pos_x range is 0..SCREEN_W-1
SCREEN_H, 480, vertical extent; pos_y range is 0..SCREEN_H-1
XW, 10, width of pos_x
YW, 9, width of pos_y
X_INIT, 320, pos_x reset value
Y_INIT, 240, pos_y reset value

Ports:
ck  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
valid  in  1  packet-available level from the register stage; may stay high for many cycles
mouseData  in  33  [32:22] frame0 (status), [21:11] frame1 (X), [10:0] frame2 (Y)
buttons  out  3  {middle,right,left}
pos_x  out  XW  cursor X
pos_y  out  YW  cursor Y, screen-down positive
dx  out  9  last accepted signed X delta
dy  out  9  last accepted signed Y delta, mouse convention (up positive)
update  out  1  one-cycle pulse when new buttons/position have been applied
frame_err  out  1  one-cycle pulse when a packet is rejected
err_count  out  8  count of rejected packets, saturating at 255

Behaviour:
- Reset (async, reset=0):
  - buttons=0, pos_x=X_INIT, pos_y=Y_INIT, dx=dy=0, update=0, frame_err=0, err_count=0.
  - FSM goes to IDLE; internal packet latch is cleared.
- Frame layout (each 11-bit frame, MSB first):
  - bit10 start (must be 0).
  - bits9:2 data d0..d7 in arrival order (bit9=d0=LSB).
  - bit1 parity: odd over d0..d7+parity.
  - bit0 stop (must be 1).
- Status byte:
  - d0 left, d1 right, d2 middle, d3 sync (must be 1).
  - d4 X sign, d5 Y sign, d6 X overflow, d7 Y overflow.
- FSM states: IDLE, CHECK, APPLY, REJECT, HOLD.
  - IDLE: when valid=1, latch mouseData, go to CHECK. Otherwise stay.
  - CHECK (1 cycle): evaluate all three frames and the sync bit.
    - Any start/stop/parity/sync failure -> REJECT.
    - Otherwise -> APPLY.
  - APPLY (1 cycle): register buttons, dx, dy, and the new pos_x/pos_y. Assert update during the cycle after this edge. Go to HOLD.
  - REJECT (1 cycle): assert frame_err; err_count+1 unless already 255. No other output changes. Go to HOLD.
  - HOLD: wait for valid=0, then go to IDLE. This gives one decode per valid assertion.
- Latency: valid sampled high at edge N -> outputs and update/frame_err pulse visible after edge N+2. update and frame_err are never both high.
- Delta arithmetic:
  - dx = {Xsign, Xbyte} as 9-bit two's complement; dy likewise.
  - If an overflow bit is set, that delta saturates to +255 (sign 0) or -256 (sign 1).
- Position arithmetic:
  - Computed in signed XW+2 / YW+2 bits.
  - nx = pos_x + dx.
  - ny = pos_y - dy (screen Y grows downward).
  - Clamp each result to [0, SCREEN_-1]; both axes are clamped independently in the same cycle.
- Button-only packets (dx=dy=0) still pulse update.
- Reset while in CHECK/APPLY/REJECT/HOLD: the in-flight packet is discarded and no pulse is emitted.
- mouseData changing while not in IDLE is ignored; the latched copy is used.

Decomposition:
- Shared package mouse_pkg holds:
  - frame field bit positions (START, DATA_MSB/LSB, PARITY, STOP);
  - status-bit indices (BTN_L, BTN_R, BTN_M, SYNC, XSIGN, YSIGN, XOVF, YOVF);
  - FSM state encoding;
  - DELTA_MAX=255, DELTA_MIN=-256.
- One natural sub-module: ps2_frame_check. It is combinational; the same instance type is used three times.
  - Input: one 11-bit frame.
  - Outputs: the 8-bit data byte and an ok flag (start, stop, odd parity).

Test Plan:
- Reset/defaults: assert reset=0 mid-run -> immediately pos=(320,240), buttons=0, err_count=0, no pulses.
- Basic packet: valid packet with status 0x09, X=0x05, Y=0x03 -> after 2 edges buttons=3'b001, dx=+5, dy=+3, pos=(325,237), update high for exactly 1 cycle.
- Negative deltas and clamping:
  - From (2,478), status 0x38 (sync, Xsign, Ysign), X=0xF6 (-10), Y=0xFB (-5) -> pos=(0,479).
  - Then status 0x08, X=0x7F, Y=0x7F applied 6 times from (0,479) -> pos_x=635 after 5 packets, then 639; pos_y reaches 0 and stays.
- Overflow: status 0x48 (X overflow, positive), X=0x12 -> dx=+255.
- Frame errors, one packet each:
  - flipped parity in frame1;
  - stop=0 in frame2;
  - status with d3=0.
  - Each -> frame_err pulse, err_count increments 1,2,3, pos/buttons unchanged.
  - After 255 bad packets err_count holds at 255.
- Held valid / mid-op reset:
  - valid held high 50 cycles -> exactly one update.
  - valid drops and rises again -> second decode.
  - reset asserted during CHECK -> no update, state returns to IDLE.
